// File: rtl/pwm_cfg_sequencer.sv
// pwm_cfg_sequencer: a Wishbone master that reprograms the PWM/timer register
// file as one ordered burst of single writes. The order is: soft-reset ctrl,
// divisor, period, duty, final ctrl. Every output is registered. An ack
// watchdog abandons the sequence if the slave never answers.
module pwm_cfg_sequencer #(
  parameter logic [15:0] ADR_CTRL = 16'h0000,
  parameter logic [15:0] ADR_DIV  = 16'h0002,
  parameter logic [15:0] ADR_PER  = 16'h0004,
  parameter logic [15:0] ADR_DUTY = 16'h0006,
  parameter int          TIMEOUT  = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_cfg_ctrl,
  input  logic [15:0] i_cfg_div,
  input  logic [15:0] i_cfg_period,
  input  logic [15:0] i_cfg_duty,
  input  logic        i_wb_ack,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [15:0] o_wb_adr,
  output logic [15:0] o_wb_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_code,
  output logic [15:0] o_ctrl_shadow
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  localparam logic [15:0] SOFT_RST_CTRL = 16'h0080;
  localparam logic [15:0] SOFT_RST_MASK = 16'hFF7F;

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_TIMEOUT = 2'd1;
  localparam logic [1:0] CODE_PER0    = 2'd2;
  localparam logic [1:0] CODE_DUTY    = 2'd3;

  // REL is shared by all gaps between writes. ret_reg remembers which write
  // comes next.
  typedef enum logic [2:0] {
    IDLE,
    W_RST,
    W_DIV,
    W_PER,
    W_DUTY,
    W_CTRL,
    REL,
    ERR
  } state_t;

  state_t        state_reg, state_next;
  state_t        ret_reg, ret_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          cyc_reg, cyc_next;
  logic          stb_reg, stb_next;
  logic          we_reg, we_next;
  logic [15:0]   adr_reg, adr_next;
  logic [15:0]   data_reg, data_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic [1:0]    code_reg, code_next;
  logic [15:0]   shadow_reg, shadow_next;
  logic [15:0]   h_ctrl_reg, h_ctrl_next;
  logic [15:0]   h_div_reg, h_div_next;
  logic [15:0]   h_per_reg, h_per_next;
  logic [15:0]   h_duty_reg, h_duty_next;

  function automatic state_t next_write(input state_t s);
    case (s)
      W_RST:   next_write = W_DIV;
      W_DIV:   next_write = W_PER;
      W_PER:   next_write = W_DUTY;
      default: next_write = W_CTRL;
    endcase
  endfunction

  function automatic logic [15:0] write_adr(input state_t s);
    case (s)
      W_DIV:   write_adr = ADR_DIV;
      W_PER:   write_adr = ADR_PER;
      W_DUTY:  write_adr = ADR_DUTY;
      default: write_adr = ADR_CTRL;
    endcase
  endfunction

  function automatic logic [15:0] write_data(input state_t s, input logic [15:0] c,
                                             input logic [15:0] d, input logic [15:0] p,
                                             input logic [15:0] u);
    case (s)
      W_RST:   write_data = SOFT_RST_CTRL;
      W_DIV:   write_data = d;
      W_PER:   write_data = p;
      W_DUTY:  write_data = u;
      W_CTRL:  write_data = c & SOFT_RST_MASK;
      default: write_data = 16'h0000;
    endcase
  endfunction

  // Next-state and next-output decode. Outputs are computed here for the
  // coming cycle and registered below, so nothing on the ports is combinational.
  always_comb begin
    state_next  = state_reg;
    ret_next    = ret_reg;
    cnt_next    = cnt_reg;
    cyc_next    = cyc_reg;
    stb_next    = stb_reg;
    we_next     = we_reg;
    adr_next    = adr_reg;
    data_next   = data_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;
    code_next   = code_reg;
    shadow_next = shadow_reg;
    h_ctrl_next = h_ctrl_reg;
    h_div_next  = h_div_reg;
    h_per_next  = h_per_reg;
    h_duty_next = h_duty_reg;

    case (state_reg)
      IDLE: begin
        if (i_start) begin
          h_ctrl_next = i_cfg_ctrl;
          h_div_next  = i_cfg_div;
          h_per_next  = i_cfg_period;
          h_duty_next = i_cfg_duty;
          code_next   = CODE_NONE;
          busy_next   = 1'b1;
          if (i_cfg_period == 16'h0000) begin
            state_next = ERR;
            code_next  = CODE_PER0;
          end else if (i_cfg_ctrl[1] && (i_cfg_duty > i_cfg_period)) begin
            state_next = ERR;
            code_next  = CODE_DUTY;
          end else begin
            state_next = W_RST;
            cyc_next   = 1'b1;
            stb_next   = 1'b1;
            we_next    = 1'b1;
            adr_next   = ADR_CTRL;
            data_next  = SOFT_RST_CTRL;
            cnt_next   = '0;
          end
        end
      end

      W_RST, W_DIV, W_PER, W_DUTY, W_CTRL: begin
        if (i_wb_ack) begin
          // An ack always wins, even on the cycle the watchdog would fire.
          cyc_next = 1'b0;
          stb_next = 1'b0;
          we_next  = 1'b0;
          if (state_reg == W_RST) begin
            shadow_next = SOFT_RST_CTRL;
          end
          if (state_reg == W_CTRL) begin
            shadow_next = h_ctrl_reg & SOFT_RST_MASK;
            done_next   = 1'b1;
            busy_next   = 1'b0;
            state_next  = IDLE;
          end else begin
            ret_next   = next_write(state_reg);
            state_next = REL;
          end
        end else if (cnt_reg == TO_LAST) begin
          cyc_next   = 1'b0;
          stb_next   = 1'b0;
          we_next    = 1'b0;
          code_next  = CODE_TIMEOUT;
          state_next = ERR;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      REL: begin
        state_next = ret_reg;
        cyc_next   = 1'b1;
        stb_next   = 1'b1;
        we_next    = 1'b1;
        adr_next   = write_adr(ret_reg);
        data_next  = write_data(ret_reg, h_ctrl_reg, h_div_reg, h_per_reg, h_duty_reg);
        cnt_next   = '0;
      end

      ERR: begin
        err_next   = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers. A reset drops the bus immediately and
  // suppresses any pending done/err pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg  <= IDLE;
      ret_reg    <= W_RST;
      cnt_reg    <= '0;
      cyc_reg    <= 1'b0;
      stb_reg    <= 1'b0;
      we_reg     <= 1'b0;
      adr_reg    <= 16'h0000;
      data_reg   <= 16'h0000;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      code_reg   <= CODE_NONE;
      shadow_reg <= 16'h0000;
      h_ctrl_reg <= 16'h0000;
      h_div_reg  <= 16'h0000;
      h_per_reg  <= 16'h0000;
      h_duty_reg <= 16'h0000;
    end else begin
      state_reg  <= state_next;
      ret_reg    <= ret_next;
      cnt_reg    <= cnt_next;
      cyc_reg    <= cyc_next;
      stb_reg    <= stb_next;
      we_reg     <= we_next;
      adr_reg    <= adr_next;
      data_reg   <= data_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      code_reg   <= code_next;
      shadow_reg <= shadow_next;
      h_ctrl_reg <= h_ctrl_next;
      h_div_reg  <= h_div_next;
      h_per_reg  <= h_per_next;
      h_duty_reg <= h_duty_next;
    end
  end

  assign o_wb_cyc      = cyc_reg;
  assign o_wb_stb      = stb_reg;
  assign o_wb_we       = we_reg;
  assign o_wb_adr      = adr_reg;
  assign o_wb_data     = data_reg;
  assign o_busy        = busy_reg;
  assign o_done        = done_reg;
  assign o_err         = err_reg;
  assign o_err_code    = code_reg;
  assign o_ctrl_shadow = shadow_reg;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Directed bench for pwm_cfg_sequencer. A registered Wishbone slave model acks
// one cycle after it sees stb. Expected writes are queued when a request is
// issued, and they are popped and compared as the DUT completes each write.
module tb_pwm_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] cfg_ctrl, cfg_div, cfg_per, cfg_duty;
  logic        ack = 1'b0;
  logic        cyc, stb, we, busy, done, err;
  logic [15:0] adr, data, shadow;
  logic [1:0]  err_code;

  int total = 0;
  int passed = 0;
  int failed = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit no_ack_per = 1'b0;
  logic [31:0] sb[$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  pwm_cfg_sequencer dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_cfg_ctrl(cfg_ctrl), .i_cfg_div(cfg_div),
    .i_cfg_period(cfg_per), .i_cfg_duty(cfg_duty),
    .i_wb_ack(ack),
    .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we),
    .o_wb_adr(adr), .o_wb_data(data),
    .o_busy(busy), .o_done(done), .o_err(err),
    .o_err_code(err_code), .o_ctrl_shadow(shadow)
  );

  // Slave model: a single-cycle ack, one cycle after stb is seen. It can be
  // told to ignore the period register.
  always @(posedge clk) begin
    ack <= !rst && stb && !ack && !(no_ack_per && adr == 16'h0004);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: each acked strobe is one write transaction.
  always @(negedge clk) begin
    if (!rst && cyc && stb && ack) begin
      $display("write adr=0x%04h data=0x%04h", adr, data);
      check("wr_we", {31'd0, we}, 32'd1);
      check("wr_expected", {31'd0, (sb.size() > 0)}, 32'd1);
      if (sb.size() > 0) begin
        mon_exp = sb.pop_front();
        check("wr_adr_data", {adr, data}, mon_exp);
      end
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
  end

  task automatic push_seq(input logic [15:0] c, input logic [15:0] d,
                          input logic [15:0] p, input logic [15:0] u);
    sb.push_back({16'h0000, 16'h0080});
    sb.push_back({16'h0002, d});
    sb.push_back({16'h0004, p});
    sb.push_back({16'h0006, u});
    sb.push_back({16'h0000, c & 16'hFF7F});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle start. It returns 1 time unit after the start edge.
  task automatic start_req(input logic [15:0] c, input logic [15:0] d,
                           input logic [15:0] p, input logic [15:0] u);
    @(negedge clk);
    cfg_ctrl = c; cfg_div = d; cfg_per = p; cfg_duty = u;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      tick();
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_adr(input logic [15:0] a);
    for (int i = 0; i < 100; i++) begin
      if (stb && adr == a) break;
      tick();
    end
    check("stb_at_adr", {31'd0, (stb && adr == a)}, 32'd1);
  endtask

  initial begin
    int d0, e0, n;
    rst = 1'b1; start = 1'b0;
    cfg_ctrl = 16'h0; cfg_div = 16'h0; cfg_per = 16'h0; cfg_duty = 16'h0;
    repeat (3) tick();
    check("rst_cyc", {31'd0, cyc}, 32'd0);
    check("rst_stb", {31'd0, stb}, 32'd0);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_adr_data", {adr, data}, 32'd0);
    check("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    check("rst_code", {30'd0, err_code}, 32'd0);
    check("rst_shadow", {16'd0, shadow}, 32'd0);
    rst = 1'b0;
    tick();

    // Nominal request with exact latency.
    d0 = done_cnt; e0 = err_cnt;
    push_seq(16'h0016, 16'd4, 16'd100, 16'd25);
    start_req(16'h0016, 16'd4, 16'd100, 16'd25);
    check("nom_busy_after_start", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 13) check("nom_done_early", {31'd0, done}, 32'd0);
    end
    check("nom_done_at_14", {31'd0, done}, 32'd1);
    check("nom_busy_at_done", {31'd0, busy}, 32'd0);
    check("nom_shadow", {16'd0, shadow}, 32'h0016);
    check("nom_sb_empty", sb.size(), 32'd0);
    tick();
    check("nom_done_once", done_cnt - d0, 32'd1);
    check("nom_no_err", err_cnt - e0, 32'd0);

    // Soft-reset bit is masked from the final ctrl write.
    push_seq(16'h00FF, 16'd1, 16'd50, 16'd10);
    start_req(16'h00FF, 16'd1, 16'd50, 16'd10);
    wait_idle();
    check("mask_shadow", {16'd0, shadow}, 32'h007F);
    check("mask_sb_empty", sb.size(), 32'd0);

    // Reject: a zero period.
    e0 = err_cnt;
    start_req(16'h0002, 16'd1, 16'd0, 16'd0);
    check("per0_busy", {31'd0, busy}, 32'd1);
    check("per0_no_cyc", {31'd0, cyc}, 32'd0);
    tick();
    check("per0_busy_drop", {31'd0, busy}, 32'd0);
    check("per0_err", {31'd0, err}, 32'd1);
    check("per0_code", {30'd0, err_code}, 32'd2);
    tick();
    check("per0_err_pulse", {31'd0, err}, 32'd0);
    check("per0_code_held", {30'd0, err_code}, 32'd2);
    check("per0_err_once", err_cnt - e0, 32'd1);

    // Reject: duty is larger than period in PWM mode.
    start_req(16'h0002, 16'd1, 16'd10, 16'd11);
    tick();
    check("duty_err", {31'd0, err}, 32'd1);
    check("duty_code", {30'd0, err_code}, 32'd3);

    // Duty is larger than period, but PWM mode is off, so it is accepted.
    d0 = done_cnt;
    push_seq(16'h0000, 16'd2, 16'd10, 16'd11);
    start_req(16'h0000, 16'd2, 16'd10, 16'd11);
    check("nopwm_code_cleared", {30'd0, err_code}, 32'd0);
    wait_idle();
    tick();
    check("nopwm_done", done_cnt - d0, 32'd1);
    check("nopwm_sb_empty", sb.size(), 32'd0);

    // Timeout: the period write is never acked.
    e0 = err_cnt;
    no_ack_per = 1'b1;
    sb.push_back({16'h0000, 16'h0080});
    sb.push_back({16'h0002, 16'd9});
    start_req(16'h0012, 16'd9, 16'd40, 16'd20);
    wait_adr(16'h0004);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (stb) n++;
      else break;
    end
    check("to_stb_cycles", n, 32'd16);
    check("to_cyc_dropped", {31'd0, cyc}, 32'd0);
    check("to_code", {30'd0, err_code}, 32'd1);
    tick();
    check("to_err", {31'd0, err}, 32'd1);
    check("to_busy", {31'd0, busy}, 32'd0);
    check("to_shadow", {16'd0, shadow}, 32'h0080);
    no_ack_per = 1'b0;
    check("to_sb_empty", sb.size(), 32'd0);
    d0 = done_cnt;
    push_seq(16'h0042, 16'd5, 16'd60, 16'd30);
    start_req(16'h0042, 16'd5, 16'd60, 16'd30);
    wait_idle();
    tick();
    check("to_recover_done", done_cnt - d0, 32'd1);
    check("to_recover_shadow", {16'd0, shadow}, 32'h0042);
    check("to_err_once", err_cnt - e0, 32'd1);

    // A start while busy is ignored.
    d0 = done_cnt;
    push_seq(16'h0012, 16'd7, 16'd200, 16'd60);
    start_req(16'h0012, 16'd7, 16'd200, 16'd60);
    wait_adr(16'h0002);
    cfg_ctrl = 16'h0033; cfg_div = 16'd99; cfg_per = 16'd300; cfg_duty = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();
    repeat (3) tick();
    check("busy_start_done_once", done_cnt - d0, 32'd1);
    check("busy_start_shadow", {16'd0, shadow}, 32'h0012);
    check("busy_start_stay_idle", {31'd0, busy}, 32'd0);
    check("busy_start_sb_empty", sb.size(), 32'd0);

    // A reset arrives during the duty write.
    d0 = done_cnt; e0 = err_cnt;
    sb.push_back({16'h0000, 16'h0080});
    sb.push_back({16'h0002, 16'd3});
    sb.push_back({16'h0004, 16'd9});
    start_req(16'h0034, 16'd3, 16'd9, 16'd9);
    wait_adr(16'h0006);
    rst = 1'b1;
    tick();
    check("rstmid_cyc_stb", {30'd0, cyc, stb}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_shadow", {16'd0, shadow}, 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("rstmid_no_done", done_cnt - d0, 32'd0);
    check("rstmid_no_err", err_cnt - e0, 32'd0);
    check("rstmid_sb_empty", sb.size(), 32'd0);
    push_seq(16'h0034, 16'd3, 16'd9, 16'd9);
    start_req(16'h0034, 16'd3, 16'd9, 16'd9);
    wait_idle();
    tick();
    check("rstmid_rerun_done", done_cnt - d0, 32'd1);
    check("rstmid_rerun_shadow", {16'd0, shadow}, 32'h0034);
    check("rstmid_rerun_sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
